// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch direction predictor.
//   ctr_t      : 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   CTR_RESET  : counter value loaded into every entry at reset
//   alloc_ctr  : counter value written when a missing entry is allocated
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // A fresh entry starts weakly biased toward the outcome that created it.
  function automatic ctr_t alloc_ctr(input logic taken);
    return taken ? WT : WNT;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next state of one 2-bit saturating counter.
// Ports:
//   cur   : current counter value
//   taken : resolved branch outcome
//   nxt   : counter value after training on `taken`
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch direction predictor and misprediction detector.
// A direct-mapped table of tagged 2-bit counters predicts the IF instruction;
// the prediction rides through the IF/ID register and is compared with the
// resolved outcome in ID. Also counts resolved branches and mispredictions.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   if_pc, if_valid         : fetch PC and its valid flag
//   if_pred_taken           : combinational prediction for if_pc
//   stall, flush            : IF/ID hold / kill controls (flush wins)
//   id_pc, id_is_branch     : ID instruction PC and branch flag
//   id_taken                : resolved outcome from the branch comparator
//   id_pred_taken           : registered prediction of the ID instruction
//   mispredict              : ID branch resolved opposite to its prediction
//   cnt_clr                 : clear statistics counters
//   br_count, mispred_count : resolved-branch and misprediction counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  output logic        if_pred_taken,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] id_pc,
  input  logic        id_is_branch,
  input  logic        id_taken,
  output logic        id_pred_taken,
  output logic        mispredict,
  input  logic        cnt_clr,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  ctr_t                ctr_q   [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, id_idx;
  logic [TAG_BITS-1:0] if_tag, id_tag;
  logic                if_hit, id_hit;
  ctr_t                if_ctr, id_ctr, ctr_trained, ctr_wr;
  logic                id_valid_q, id_pred_q;
  logic                resolve;

  // Only the index and tag fields of the PCs address the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, id_pc};

  // IF stage: table lookup
  assign if_idx        = if_pc[IDX_BITS+1:2];
  assign if_tag        = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign if_ctr        = ctr_q[if_idx];
  assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred_taken = if_valid & if_hit & if_ctr[1];

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
    end else if (!stall) begin
      id_valid_q <= if_valid;
      id_pred_q  <= if_pred_taken;
    end
  end

  // ID stage: resolve, detect misprediction, train the table.
  // A stalled branch is resolved only in the cycle it advances, so it is
  // counted and trained exactly once.
  assign id_pred_taken = id_pred_q & id_valid_q;
  assign resolve       = id_valid_q & id_is_branch & ~stall;
  assign mispredict    = resolve & (id_taken != id_pred_q);

  assign id_idx = id_pc[IDX_BITS+1:2];
  assign id_tag = id_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign id_ctr = ctr_q[id_idx];
  assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

  sat_counter2 u_sat (
    .cur   (id_ctr),
    .taken (id_taken),
    .nxt   (ctr_trained)
  );

  assign ctr_wr = id_hit ? ctr_trained : alloc_ctr(id_taken);

  // Same-cycle IF read of the written index sees the old entry (no bypass).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (resolve) begin
      valid_q[id_idx] <= 1'b1;
      tag_q[id_idx]   <= id_tag;
      ctr_q[id_idx]   <= ctr_wr;
    end
  end

  // Statistics counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (resolve)    br_count      <= br_count + 32'd1;
      if (mispredict) mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural model is compared
// against the DUT on every falling edge, plus directed literal checks.
module tb_branch_predictor;

  localparam int N    = 64;   // 2^IDX_BITS
  localparam int TAGN = 256;  // 2^TAG_BITS

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_valid = 1'b0;
  logic        if_pred_taken;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] id_pc = '0;
  logic        id_is_branch = 1'b0;
  logic        id_taken = 1'b0;
  logic        id_pred_taken;
  logic        mispredict;
  logic        cnt_clr = 1'b0;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .TAG_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .if_pred_taken (if_pred_taken),
    .stall         (stall),
    .flush         (flush),
    .id_pc         (id_pc),
    .id_is_branch  (id_is_branch),
    .id_taken      (id_taken),
    .id_pred_taken (id_pred_taken),
    .mispredict    (mispredict),
    .cnt_clr       (cnt_clr),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [N];
  int          m_tag   [N];
  int          m_ctr   [N];   // 0..3, taken predicted when >= 2
  bit          m_idv, m_idp;
  logic [31:0] m_br, m_mis;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_idv = 1'b0;
    m_idp = 1'b0;
    m_br  = '0;
    m_mis = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int  fi, ft, ri, rt;
    bit  fhit, rhit, e_if, e_id, res, e_mis;
    fi   = int'(if_pc / 4) % N;
    ft   = int'(if_pc / (4 * N)) % TAGN;
    fhit = m_valid[fi] && (m_tag[fi] == ft);
    e_if = if_valid && fhit && (m_ctr[fi] >= 2);
    e_id = m_idv && m_idp;
    res  = m_idv && id_is_branch && !stall;
    e_mis = res && (id_taken != m_idp);

    check1("model_if_pred", if_pred_taken, e_if);
    check1("model_id_pred", id_pred_taken, e_id);
    check1("model_mispredict", mispredict, e_mis);
    check32("model_br_count", br_count, m_br);
    check32("model_mispred_count", mispred_count, m_mis);

    if (rst) begin
      model_reset();
    end else begin
      if (res) begin
        ri   = int'(id_pc / 4) % N;
        rt   = int'(id_pc / (4 * N)) % TAGN;
        rhit = m_valid[ri] && (m_tag[ri] == rt);
        if (rhit) begin
          if (id_taken) m_ctr[ri] = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
          else          m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
        end else begin
          m_valid[ri] = 1'b1;
          m_tag[ri]   = rt;
          m_ctr[ri]   = id_taken ? 2 : 1;
        end
      end
      if (flush) begin
        m_idv = 1'b0;
        m_idp = 1'b0;
      end else if (!stall) begin
        m_idv = if_valid;
        m_idp = e_if;
      end
      if (cnt_clr) begin
        m_br  = '0;
        m_mis = '0;
      end else begin
        if (res)   m_br  = m_br + 32'd1;
        if (e_mis) m_mis = m_mis + 32'd1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_pc = '0; if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    id_pc = '0; id_is_branch = 1'b0; id_taken = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic check_cnt(input logic [31:0] eb, input logic [31:0] em);
    check32("br_count", br_count, eb);
    check32("mispred_count", mispred_count, em);
  endtask

  // Fetch pc in one cycle, resolve it in ID the next.
  task automatic branch(input logic [31:0] pc, input logic tk,
                        input logic ep, input logic em);
    idle(); if_pc = pc; if_valid = 1'b1;
    #1 check1("fetch_pred", if_pred_taken, ep);
    cyc();
    idle(); id_pc = pc; id_is_branch = 1'b1; id_taken = tk;
    #1 check1("id_pred", id_pred_taken, ep);
    check1("resolve_mispredict", mispredict, em);
    cyc();
    idle();
  endtask

  logic [31:0] pcs [5];

  initial begin
    pcs = '{32'h100, 32'h104, 32'h200, 32'h300, 32'h108};
    idle();
    rst = 1'b1;
    cyc(); cyc();
    if_pc = 32'h100; if_valid = 1'b1;
    #1 check1("reset_if_pred", if_pred_taken, 1'b0);
    check1("reset_id_pred", id_pred_taken, 1'b0);
    check1("reset_mispredict", mispredict, 1'b0);
    check_cnt(32'd0, 32'd0);
    rst = 1'b0;
    idle();
    cyc();

    // Train 0x100 taken: WT, ST, ST; only the first is mispredicted.
    branch(32'h100, 1'b1, 1'b0, 1'b1);
    branch(32'h100, 1'b1, 1'b1, 1'b0);
    branch(32'h100, 1'b1, 1'b1, 1'b0);
    if_pc = 32'h100; if_valid = 1'b1;
    #1 check1("trained_pred", if_pred_taken, 1'b1);
    check_cnt(32'd3, 32'd1);
    idle();

    // Alias 0x200 (same index, different tag) evicts 0x100.
    branch(32'h200, 1'b0, 1'b0, 1'b0);
    branch(32'h100, 1'b1, 1'b0, 1'b1);
    check_cnt(32'd5, 32'd2);

    // Stall three cycles with a predicted-taken branch in ID.
    idle(); if_pc = 32'h100; if_valid = 1'b1;
    #1 check1("stall_fetch_pred", if_pred_taken, 1'b1);
    cyc();
    idle(); id_pc = 32'h100; id_is_branch = 1'b1; id_taken = 1'b0; stall = 1'b1;
    repeat (3) begin
      #1 check1("stall_id_pred", id_pred_taken, 1'b1);
      check1("stall_mispredict", mispredict, 1'b0);
      cyc();
      check32("stall_br_count", br_count, 32'd5);
    end
    stall = 1'b0;
    #1 check1("release_mispredict", mispredict, 1'b1);
    cyc();
    check_cnt(32'd6, 32'd3);
    idle();

    // Flush (with stall) a predicted-taken fetch.
    branch(32'h104, 1'b1, 1'b0, 1'b1);
    if_pc = 32'h104; if_valid = 1'b1; flush = 1'b1; stall = 1'b1;
    #1 check1("flush_fetch_pred", if_pred_taken, 1'b1);
    cyc();
    idle(); id_pc = 32'h104; id_is_branch = 1'b1; id_taken = 1'b1;
    #1 check1("flushed_id_pred", id_pred_taken, 1'b0);
    check1("flushed_mispredict", mispredict, 1'b0);
    cyc();
    check_cnt(32'd7, 32'd4);
    idle();

    // A resolve coinciding with flush still trains (WT -> ST).
    if_pc = 32'h104; if_valid = 1'b1;
    cyc();
    idle(); id_pc = 32'h104; id_is_branch = 1'b1; id_taken = 1'b1;
    flush = 1'b1; if_pc = 32'h104; if_valid = 1'b1;
    #1 check1("flush_resolve_mispredict", mispredict, 1'b0);
    cyc();
    check_cnt(32'd8, 32'd4);
    idle();
    branch(32'h104, 1'b0, 1'b1, 1'b1);   // ST -> WT, still taken

    // Clear beats a same-cycle increment.
    if_pc = 32'h104; if_valid = 1'b1;
    #1 check1("clr_fetch_pred", if_pred_taken, 1'b1);
    cyc();
    idle(); id_pc = 32'h104; id_is_branch = 1'b1; id_taken = 1'b0; cnt_clr = 1'b1;
    #1 check1("clr_mispredict", mispredict, 1'b1);
    cyc();
    check_cnt(32'd0, 32'd0);
    idle();
    branch(32'h104, 1'b1, 1'b0, 1'b1);   // WNT -> WT
    check_cnt(32'd1, 32'd1);

    // Mid-stream reset clears table and counters.
    if_pc = 32'h104; if_valid = 1'b1;
    cyc();
    idle(); id_pc = 32'h104; id_is_branch = 1'b1; id_taken = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle(); if_pc = 32'h104; if_valid = 1'b1;
    #1 check1("post_reset_pred", if_pred_taken, 1'b0);
    check1("post_reset_id_pred", id_pred_taken, 1'b0);
    check_cnt(32'd0, 32'd0);
    cyc();
    idle();

    // Mixed traffic, checked by the model every cycle.
    for (int k = 0; k < 300; k++) begin
      int a, b;
      a = $urandom_range(0, 4);
      b = $urandom_range(0, 4);
      if_pc        = pcs[a];
      if_valid     = ($urandom_range(0, 3) != 0);
      id_pc        = pcs[b];
      id_is_branch = ($urandom_range(0, 2) != 0);
      id_taken     = ($urandom_range(0, 1) == 1);
      stall        = ($urandom_range(0, 5) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      cnt_clr      = ($urandom_range(0, 40) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direction predictor and misprediction detector for the 5-stage RISC-V core. It predicts taken/not-taken for the instruction in IF using a direct-mapped table of tagged 2-bit saturating counters. It carries that prediction through the IF/ID boundary and compares it against the branch comparator's resolved `branch_judge` in ID. On a mismatch it raises `mispredict`, so the PC-select logic redirects fetch and flushes IF. It also keeps branch and misprediction counters for the CSR file.

## Interface
Parameters:
- `IDX_BITS`, 6, table index width; the table holds 2^IDX_BITS entries.
- `TAG_BITS`, 8, tag width per entry; IDX_BITS + TAG_BITS must be at most 30.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `if_pc`  in  32  PC currently being fetched.
- `if_valid`  in  1  IF holds a real instruction.
- `if_pred_taken`  out  1  prediction for `if_pc`, combinational.
- `stall`  in  1  hold the IF/ID boundary.
- `flush`  in  1  kill the instruction entering ID.
- `id_pc`  in  32  PC of the instruction in ID.
- `id_is_branch`  in  1  the ID instruction is a conditional branch.
- `id_taken`  in  1  resolved outcome, the comparator's `branch_judge`.
- `id_pred_taken`  out  1  registered prediction for the ID instruction.
- `mispredict`  out  1  ID branch resolved opposite to its prediction.
- `cnt_clr`  in  1  clear both statistics counters.
- `br_count`  out  32  number of resolved branches.
- `mispred_count`  out  32  number of mispredictions.

## Operation
- Index is `pc[IDX_BITS+1:2]`.
- Tag is `pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]`.
- Each entry holds `valid`, `tag` and a 2-bit counter:
  - SNT = 00, WNT = 01, WT = 10, ST = 11.
- Prediction: `if_pred_taken = if_valid & hit & ctr[1]`, where hit means the entry is valid and its tag matches. A miss predicts not-taken.
- IF/ID register (`id_valid_q`, `id_pred_q`), updated every cycle by priority:
  - `flush` loads 0/0.
  - otherwise `stall` holds.
  - otherwise it loads `if_valid` and `if_pred_taken`.
- `id_pred_taken = id_pred_q & id_valid_q`.
- A resolve event is `id_valid_q & id_is_branch & ~stall`. It happens at most once per instruction, because a stalled branch is not counted until it advances.
- `mispredict = resolve & (id_taken != id_pred_q)`.
- Table update on each resolve, indexed by `id_pc`:
  - On a hit: saturating increment if taken, saturating decrement if not. 11 stays at 11 on taken; 00 stays at 00 on not-taken.
  - On a miss: allocate the entry (valid = 1, tag = `id_pc` tag) with counter WT if taken, WNT if not.
- Statistics counters:
  - `br_count` increments on each resolve; `mispred_count` increments on each mispredict.
  - Both wrap modulo 2^32.
  - `cnt_clr` zeroes both and takes priority over an increment in the same cycle.
- Reset: all entries invalid with counter WNT; `id_valid_q = 0`, `id_pred_q = 0`; both counters 0. Consequently `if_pred_taken`, `id_pred_taken` and `mispredict` are all 0 during and immediately after reset.

## Timing
- Prediction is available in the same cycle as `if_pc`.
- `id_pred_taken` reflects that prediction one cycle after an unstalled, unflushed accept.
- `mispredict` is combinational in the ID cycle; the consumer registers the redirect.
- A table write at edge N is visible to predictions from cycle N+1.
- If IF reads and ID writes the same index in the same cycle, IF sees the old value; there is no bypass.
- `flush` and `stall` asserted together: flush wins.
- A resolve in the same cycle as `flush` still updates the table. Flush affects only the instruction entering ID, not the one resolving.
- `rst` asserted mid-stream clears all state at the next edge, regardless of any other input.
- Counter outputs are registered and change one edge after the event.

## Structure
- Shared defines header: counter encodings SNT/WNT/WT/ST and the reset counter value.
- Sub-module `sat_counter2`: combinational next-state of one 2-bit counter from its current value and `taken`. One instance serves the update path.
- Table storage is flop arrays (`valid`, `tag`, `ctr`), so reset can clear them in one cycle. No SRAM.

## Test plan
- Reset, then `if_pc = 0x100`, `if_valid = 1` -> `if_pred_taken = 0`, both counters 0.
- Resolve the branch at 0x100 as taken three times -> entry goes WT, ST, ST; the next fetch of 0x100 predicts 1; `br_count = 3`, `mispred_count = 1` (first resolve predicted 0).
- Train 0x100 to ST, then fetch 0x100 + 4·2^IDX_BITS (same index, different tag) -> prediction 0. Resolving it as not-taken reallocates the entry at WNT, and a later fetch of 0x100 predicts 0.
- Hold `stall` for 3 cycles with a branch in ID -> `id_pred_taken` is held, `br_count` rises by exactly 1 after release, and `mispredict` pulses only in the unstalled cycle.
- Assert `flush` with a predicted-taken instruction in IF -> next cycle `id_pred_taken = 0` and `mispredict = 0`, even with `id_is_branch = 1` and `id_taken = 1`.
- Preload `br_count = 0xFFFFFFFF` by driving events, then resolve once -> 0. Assert `cnt_clr` and resolve in the same cycle -> both counters 0.
